// File: rtl/sfilt_mc.sv
// sfilt_mc: multi-channel, fully pipelined serial filter engine.
// Four-stage pipeline (S0 capture, S1 multiply, S2 delay, S3 accumulate/output)
// with one accumulator per channel. The accumulator is read and written back in
// S3 only, so back-to-back commands to one channel never need forwarding.
// Optional feature macro: SFILT_SAT_EN (saturating output conversion on cmd 3).
module sfilt_mc #(
  parameter int DW  = 32,
  parameter int AW  = 64,
  parameter int NCH = 4,
  parameter int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           pushin,
  input  logic [1:0]     cmd,
  input  logic [CHW-1:0] ch,
  input  logic [DW-1:0]  q,
  input  logic [DW-1:0]  h,
  output logic           pushout,
  output logic [CHW-1:0] zch,
  output logic [DW-1:0]  z
);

`ifdef SFILT_SAT_EN
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
`endif

  // Convert an accumulator value to the DW-bit result presented on z.
  function automatic logic [DW-1:0] f_out_conv(input logic [AW-1:0] acc);
`ifdef SFILT_SAT_EN
    logic signed [AW-1:0] v_s;
    v_s = $signed(acc);
    if (v_s > SAT_MAX) begin
      return SAT_MAX[DW-1:0];
    end else if (v_s < SAT_MIN) begin
      return SAT_MIN[DW-1:0];
    end else begin
      return acc[DW-1:0];
    end
`else
    return acc[DW-1:0];
`endif
  endfunction

  // S0 registers
  logic                 r_v0;
  logic [1:0]           r_cmd0;
  logic [CHW-1:0]       r_ch0;
  logic signed [DW-1:0] r_q0;
  logic signed [DW-1:0] r_h0;
  logic [6:0]           r_sh0;
  // S1 registers
  logic                 r_v1;
  logic [1:0]           r_cmd1;
  logic [CHW-1:0]       r_ch1;
  logic [6:0]           r_sh1;
  logic [AW-1:0]        r_p1;
  // S2 registers
  logic                 r_v2;
  logic [1:0]           r_cmd2;
  logic [CHW-1:0]       r_ch2;
  logic [6:0]           r_sh2;
  logic [AW-1:0]        r_p2;
  // Accumulators
  logic [AW-1:0]        r_acc [NCH];

  logic signed [2*DW-1:0] w_prod;
  logic signed [AW-1:0]   w_prod_ext;
  logic [31:0]            w_ch_ext;
  logic                   w_hit;
  logic [AW-1:0]          w_acc_rd;
  logic [AW-1:0]          w_asr;
  logic [AW-1:0]          w_rnd_src;
  logic [AW-1:0]          w_acc_nx;

  // Full-width signed product, then sign-extended to the accumulator width.
  assign w_prod     = (2*DW)'(r_q0) * (2*DW)'(r_h0);
  assign w_prod_ext = AW'(w_prod);

  // Channel tags beyond NCH are dropped in S3 but still occupy their slot.
  assign w_ch_ext = 32'(r_ch2);
  assign w_hit    = r_v2 && (w_ch_ext < 32'(NCH));

  // Capture the incoming command into S0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v0   <= 1'b0;
      r_cmd0 <= 2'd0;
      r_ch0  <= {CHW{1'b0}};
      r_q0   <= {DW{1'b0}};
      r_h0   <= {DW{1'b0}};
      r_sh0  <= 7'd0;
    end else begin
      r_v0   <= pushin;
      r_cmd0 <= cmd;
      r_ch0  <= ch;
      r_q0   <= q;
      r_h0   <= h;
      r_sh0  <= h[6:0];
    end
  end

  // S1 multiplies and S2 delays the product and its control alongside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_cmd1 <= 2'd0;
      r_ch1  <= {CHW{1'b0}};
      r_sh1  <= 7'd0;
      r_p1   <= {AW{1'b0}};
      r_v2   <= 1'b0;
      r_cmd2 <= 2'd0;
      r_ch2  <= {CHW{1'b0}};
      r_sh2  <= 7'd0;
      r_p2   <= {AW{1'b0}};
    end else begin
      r_v1   <= r_v0;
      r_cmd1 <= r_cmd0;
      r_ch1  <= r_ch0;
      r_sh1  <= r_sh0;
      r_p1   <= w_prod_ext;
      r_v2   <= r_v1;
      r_cmd2 <= r_cmd1;
      r_ch2  <= r_ch1;
      r_sh2  <= r_sh1;
      r_p2   <= r_p1;
    end
  end

  // Select the addressed accumulator and compute its next value for S3.
  always_comb begin
    w_acc_rd  = {AW{1'b0}};
    w_asr     = {AW{1'b0}};
    w_rnd_src = {AW{1'b0}};
    w_acc_nx  = {AW{1'b0}};
    if (w_hit) begin
      w_acc_rd = r_acc[r_ch2];
    end else begin
      w_acc_rd = {AW{1'b0}};
    end
    w_asr     = $signed(w_acc_rd) >>> r_sh2;
    // Bit s-1 of the accumulator is the rounding bit (half rounds toward +inf).
    w_rnd_src = w_acc_rd >> (r_sh2 - 7'd1);
    case (r_cmd2)
      2'd0: w_acc_nx = r_p2;
      2'd1: w_acc_nx = w_acc_rd + r_p2;
      2'd2: begin
        if (r_sh2 == 7'd0) begin
          w_acc_nx = w_acc_rd;
        end else if ({25'd0, r_sh2} >= 32'(AW)) begin
          w_acc_nx = {AW{1'b0}};
        end else begin
          w_acc_nx = w_asr + {{(AW-1){1'b0}}, w_rnd_src[0]};
        end
      end
      2'd3: w_acc_nx = {AW{1'b0}};
      default: w_acc_nx = w_acc_rd;
    endcase
  end

  // S3 write-back: only the addressed, in-range channel is updated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        r_acc[i] <= {AW{1'b0}};
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_hit && (w_ch_ext == 32'(i))) begin
          r_acc[i] <= w_acc_nx;
        end
      end
    end
  end

  // S3 output register: one-cycle pulse per executed cmd 3, z/zch hold between.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pushout <= 1'b0;
      zch     <= {CHW{1'b0}};
      z       <= {DW{1'b0}};
    end else begin
      pushout <= w_hit && (r_cmd2 == 2'd3);
      if (w_hit && (r_cmd2 == 2'd3)) begin
        zch <= r_ch2;
        z   <= f_out_conv(w_acc_rd);
      end
    end
  end

endmodule

// File: tb/tb_sfilt_mc.sv
// Self-checking bench for sfilt_mc (DW=32, AW=64, NCH=4) plus an NCH=5 instance
// that exercises dropped channel tags. Inputs change on the falling edge; the
// same process samples outputs there, so latency is counted in whole cycles.
module tb_sfilt_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pushin = 1'b0;
  logic [1:0]  cmd = 2'd0;
  logic [1:0]  ch = 2'd0;
  logic [31:0] q_in = 32'd0;
  logic [31:0] h_in = 32'd0;
  logic        pushout;
  logic [1:0]  zch;
  logic [31:0] z;

  logic        pushin5 = 1'b0;
  logic [1:0]  cmd5 = 2'd0;
  logic [2:0]  ch5 = 3'd0;
  logic [31:0] q5 = 32'd0;
  logic [31:0] h5 = 32'd0;
  logic        pushout5;
  logic [2:0]  zch5;
  logic [31:0] z5;

  sfilt_mc #(.DW(32), .AW(64), .NCH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .pushin(pushin), .cmd(cmd), .ch(ch),
    .q(q_in), .h(h_in), .pushout(pushout), .zch(zch), .z(z)
  );

  sfilt_mc #(.DW(32), .AW(64), .NCH(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .pushin(pushin5), .cmd(cmd5), .ch(ch5),
    .q(q5), .h(h5), .pushout(pushout5), .zch(zch5), .z(z5)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] z;
    logic [2:0]  zch;
    int          cyc;
  } exp_t;

  typedef struct {
    bit          v;
    logic [1:0]  cmd;
    logic [1:0]  ch;
    logic [31:0] q;
    logic [31:0] h;
    logic [31:0] ez;
  } vec_t;

  localparam int NV = 35;
`ifdef SFILT_SAT_EN
  localparam logic [31:0] E_POS = 32'h7FFFFFFF;
  localparam logic [31:0] E_NEG = 32'h80000000;
  localparam logic [31:0] E_MAC = 32'h7FFFFFFF;
`else
  localparam logic [31:0] E_POS = 32'h00000000;
  localparam logic [31:0] E_NEG = 32'h00000000;
  localparam logic [31:0] E_MAC = 32'hFFFFFFFF;
`endif

  vec_t tv [NV];
  exp_t exp_q[$];
  exp_t exp_q5[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) begin
      n_pass++;
    end else begin
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, expv);
    end
  endtask

  // Compare both instances' outputs against the pulses due in this cycle.
  task automatic sample();
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      check("pushout", {63'd0, pushout}, 64'd1);
      check("z", {32'd0, z}, {32'd0, exp_q[0].z});
      check("zch", {62'd0, zch}, {61'd0, exp_q[0].zch});
      void'(exp_q.pop_front());
    end else begin
      check("pushout_idle", {63'd0, pushout}, 64'd0);
    end
    if (exp_q5.size() > 0 && exp_q5[0].cyc == cyc) begin
      check("pushout5", {63'd0, pushout5}, 64'd1);
      check("z5", {32'd0, z5}, {32'd0, exp_q5[0].z});
      check("zch5", {61'd0, zch5}, {61'd0, exp_q5[0].zch});
      void'(exp_q5.pop_front());
    end else begin
      check("pushout5_idle", {63'd0, pushout5}, 64'd0);
    end
  endtask

  // One cycle on the NCH=4 instance.
  task automatic drive(input bit rst_v, input bit v, input logic [1:0] c,
                       input logic [1:0] chn, input logic [31:0] qq,
                       input logic [31:0] hh, input bit exp_en, input logic [31:0] ez);
    exp_t e;
    @(negedge clk);
    cyc++;
    sample();
    rst_n   = rst_v;
    pushin  = v;
    cmd     = c;
    ch      = chn;
    q_in    = qq;
    h_in    = hh;
    pushin5 = 1'b0;
    if (v && c == 2'd3 && exp_en) begin
      e.z = ez; e.zch = {1'b0, chn}; e.cyc = cyc + 4;
      exp_q.push_back(e);
    end
  endtask

  // One cycle on the NCH=5 instance.
  task automatic drive5(input bit v, input logic [1:0] c, input logic [2:0] chn,
                        input logic [31:0] qq, input logic [31:0] hh,
                        input bit exp_en, input logic [31:0] ez);
    exp_t e;
    @(negedge clk);
    cyc++;
    sample();
    rst_n   = 1'b1;
    pushin  = 1'b0;
    pushin5 = v;
    cmd5    = c;
    ch5     = chn;
    q5      = qq;
    h5      = hh;
    if (v && c == 2'd3 && exp_en) begin
      e.z = ez; e.zch = chn; e.cyc = cyc + 4;
      exp_q5.push_back(e);
    end
  endtask

  initial begin
    tv[0]  = '{1'b1, 2'd0, 2'd1, 32'd3,          32'd5,   32'd0};
    tv[1]  = '{1'b1, 2'd1, 2'd1, 32'hFFFFFFFE,   32'd4,   32'd0};
    tv[2]  = '{1'b1, 2'd3, 2'd1, 32'd0,          32'd0,   32'd7};
    tv[3]  = '{1'b1, 2'd3, 2'd1, 32'd0,          32'd0,   32'd0};
    tv[4]  = '{1'b1, 2'd0, 2'd0, 32'd10,         32'd10,  32'd0};
    tv[5]  = '{1'b1, 2'd0, 2'd2, 32'hFFFFFFFF,   32'd1,   32'd0};
    tv[6]  = '{1'b1, 2'd1, 2'd0, 32'd1,          32'd1,   32'd0};
    tv[7]  = '{1'b1, 2'd3, 2'd0, 32'd0,          32'd0,   32'd101};
    tv[8]  = '{1'b1, 2'd3, 2'd2, 32'd0,          32'd0,   32'hFFFFFFFF};
    tv[9]  = '{1'b0, 2'd3, 2'd0, 32'd0,          32'd0,   32'd0};
    tv[10] = '{1'b1, 2'd0, 2'd3, 32'd7,          32'd1,   32'd0};
    tv[11] = '{1'b1, 2'd2, 2'd3, 32'd9,          32'd1,   32'd0};
    tv[12] = '{1'b1, 2'd3, 2'd3, 32'd0,          32'd0,   32'd4};
    tv[13] = '{1'b1, 2'd0, 2'd3, 32'hFFFFFFF9,   32'd1,   32'd0};
    tv[14] = '{1'b1, 2'd2, 2'd3, 32'd9,          32'd1,   32'd0};
    tv[15] = '{1'b1, 2'd3, 2'd3, 32'd0,          32'd0,   32'hFFFFFFFD};
    tv[16] = '{1'b1, 2'd0, 2'd3, 32'd5,          32'd1,   32'd0};
    tv[17] = '{1'b1, 2'd2, 2'd3, 32'd9,          32'd0,   32'd0};
    tv[18] = '{1'b1, 2'd3, 2'd3, 32'd0,          32'd0,   32'd5};
    tv[19] = '{1'b1, 2'd0, 2'd3, 32'hFFFFFFF9,   32'd1,   32'd0};
    tv[20] = '{1'b1, 2'd2, 2'd3, 32'd9,          32'd100, 32'd0};
    tv[21] = '{1'b1, 2'd3, 2'd3, 32'd0,          32'd0,   32'd0};
    tv[22] = '{1'b1, 2'd0, 2'd2, 32'hFFFFFFFA,   32'd1,   32'd0};
    tv[23] = '{1'b1, 2'd2, 2'd2, 32'd0,          32'd2,   32'd0};
    tv[24] = '{1'b1, 2'd3, 2'd2, 32'd0,          32'd0,   32'hFFFFFFFF};
    tv[25] = '{1'b1, 2'd0, 2'd1, 32'd7,          32'd1,   32'd0};
    tv[26] = '{1'b1, 2'd2, 2'd1, 32'd0,          32'd64,  32'd0};
    tv[27] = '{1'b1, 2'd3, 2'd1, 32'd0,          32'd0,   32'd0};
    tv[28] = '{1'b1, 2'd0, 2'd0, 32'h40000000,   32'd4,   32'd0};
    tv[29] = '{1'b1, 2'd3, 2'd0, 32'd0,          32'd0,   E_POS};
    tv[30] = '{1'b1, 2'd0, 2'd0, 32'hC0000000,   32'd4,   32'd0};
    tv[31] = '{1'b1, 2'd3, 2'd0, 32'd0,          32'd0,   E_NEG};
    tv[32] = '{1'b1, 2'd0, 2'd2, 32'h40000000,   32'd4,   32'd0};
    tv[33] = '{1'b1, 2'd1, 2'd2, 32'hFFFFFFFF,   32'd1,   32'd0};
    tv[34] = '{1'b1, 2'd3, 2'd2, 32'd0,          32'd0,   E_MAC};

    // Reset held with pushin toggling: nothing may come out.
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, i[0], 2'd3, 2'd0, 32'd1, 32'd1, 1'b0, 32'd0);
      check("rst_pushout", {63'd0, pushout}, 64'd0);
      check("rst_z", {32'd0, z}, 64'd0);
      check("rst_zch", {62'd0, zch}, 64'd0);
    end
    // First command accepted in the first cycle with rst_n high.
    drive(1'b1, 1'b1, 2'd3, 2'd0, 32'd0, 32'd0, 1'b1, 32'd0);

    for (int i = 0; i < NV; i++) begin
      drive(1'b1, tv[i].v, tv[i].cmd, tv[i].ch, tv[i].q, tv[i].h, 1'b1, tv[i].ez);
    end
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 2'd0, 2'd0, 32'd0, 32'd0, 1'b0, 32'd0);

    // Reset mid-operation: the in-flight cmd 3 must never produce a pulse.
    drive(1'b1, 1'b1, 2'd0, 2'd0, 32'd2, 32'd3, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 2'd0, 2'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    drive(1'b1, 1'b1, 2'd3, 2'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 2'd0, 2'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 2'd0, 2'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 2'd0, 2'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    check("midrst_pushout", {63'd0, pushout}, 64'd0);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 2'd0, 2'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    drive(1'b1, 1'b1, 2'd3, 2'd0, 32'd0, 32'd0, 1'b1, 32'd0);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 2'd0, 2'd0, 32'd0, 32'd0, 1'b0, 32'd0);

    // Dropped channel tags on the NCH=5 instance leave every accumulator alone.
    drive5(1'b1, 2'd0, 3'd0, 32'd3, 32'd5, 1'b0, 32'd0);
    drive5(1'b1, 2'd0, 3'd5, 32'd7, 32'd7, 1'b0, 32'd0);
    drive5(1'b1, 2'd1, 3'd5, 32'd7, 32'd7, 1'b0, 32'd0);
    drive5(1'b1, 2'd3, 3'd5, 32'd0, 32'd0, 1'b0, 32'd0);
    drive5(1'b1, 2'd0, 3'd7, 32'd9, 32'd9, 1'b0, 32'd0);
    drive5(1'b1, 2'd1, 3'd0, 32'd1, 32'd1, 1'b0, 32'd0);
    drive5(1'b1, 2'd3, 3'd0, 32'd0, 32'd0, 1'b1, 32'd16);
    drive5(1'b1, 2'd3, 3'd4, 32'd0, 32'd0, 1'b1, 32'd0);
    drive5(1'b1, 2'd3, 3'd6, 32'd0, 32'd0, 1'b0, 32'd0);
    for (int i = 0; i < 8; i++) drive5(1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 1'b0, 32'd0);

    check("pulses_left", 64'(exp_q.size()), 64'd0);
    check("pulses5_left", 64'(exp_q5.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
